// File: rtl/alu_pkg.sv
// Shared definitions for the ALU logic unit: opcode encodings and the reference
// bitwise evaluation function used by both the datapath and its models.
package alu_pkg;

    localparam int LU_OP_W = 3;

    localparam logic [LU_OP_W-1:0] LU_AND   = 3'd0;
    localparam logic [LU_OP_W-1:0] LU_OR    = 3'd1;
    localparam logic [LU_OP_W-1:0] LU_XOR   = 3'd2;
    localparam logic [LU_OP_W-1:0] LU_NOR   = 3'd3;
    localparam logic [LU_OP_W-1:0] LU_NAND  = 3'd4;
    localparam logic [LU_OP_W-1:0] LU_XNOR  = 3'd5;
    localparam logic [LU_OP_W-1:0] LU_PASSA = 3'd6;
    localparam logic [LU_OP_W-1:0] LU_NOTA  = 3'd7;

    // Evaluated at the widest legal operand size; callers keep the low WIDTH bits,
    // which is exact because no operation moves information between bit positions.
    function automatic logic [63:0] lu_eval(input logic [LU_OP_W-1:0] op,
                                            input logic [63:0]        a,
                                            input logic [63:0]        b);
        logic [63:0] r;
        r = '0;
        case (op)
            LU_AND:   r = a & b;
            LU_OR:    r = a | b;
            LU_XOR:   r = a ^ b;
            LU_NOR:   r = ~(a | b);
            LU_NAND:  r = ~(a & b);
            LU_XNOR:  r = ~(a ^ b);
            LU_PASSA: r = a;
            LU_NOTA:  r = ~a;
            default:  r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/logic_unit_pipe_if.sv
// Operand/result handshake bundle between operand fetch, the logic unit and
// the ALU writeback mux. slave = the logic unit, master = its environment.
interface logic_unit_pipe_if
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) ();
    logic               in_valid;
    logic               in_ready;
    logic [LU_OP_W-1:0] op;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out;
    logic               zero;
    logic               ones;
    logic               parity;

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, out, zero, ones, parity
    );

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, out, zero, ones, parity
    );
endinterface

// File: rtl/logic_unit_core.sv
// Combinational op mux plus zero/all-ones/parity flags for one operand set.
module logic_unit_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [LU_OP_W-1:0] op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [WIDTH-1:0]   res,
    output logic               zero,
    output logic               ones,
    output logic               parity
);
    assign res    = WIDTH'(lu_eval(op, 64'(a), 64'(b)));
    assign zero   = ~|res;
    assign ones   = &res;
    assign parity = ^res;
endmodule

// File: rtl/logic_unit_pipe.sv
// Pipelined WIDTH-bit logic unit with a registered valid/ready result stage.
// Define LOGIC_UNIT_SKID_EN to add a one-entry skid buffer and a registered in_ready.
module logic_unit_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int OP_W  = LU_OP_W
) (
    input logic              clk,
    input logic              rst,
    logic_unit_pipe_if.slave bus
);
    logic [OP_W-1:0]  op_in;
    logic [WIDTH-1:0] in_res;
    logic             in_zero;
    logic             in_ones;
    logic             in_parity;

    logic [WIDTH-1:0] out_q;
    logic             zero_q;
    logic             ones_q;
    logic             parity_q;
    logic             out_valid_q;

    logic             in_fire;
    logic             out_fire;

    assign op_in = bus.op;

    logic_unit_core #(.WIDTH(WIDTH)) u_core_in (
        .op     (op_in),
        .a      (bus.a),
        .b      (bus.b),
        .res    (in_res),
        .zero   (in_zero),
        .ones   (in_ones),
        .parity (in_parity)
    );

    assign out_fire = out_valid_q && bus.out_ready;

`ifdef LOGIC_UNIT_SKID_EN
    // The skid keeps the accepted operands; a second core turns them into the
    // result so the stalled value is ready the moment the output drains.
    logic             skid_full;
    logic             in_ready_q;
    logic [OP_W-1:0]  skid_op;
    logic [WIDTH-1:0] skid_a;
    logic [WIDTH-1:0] skid_b;
    logic [WIDTH-1:0] skid_res;
    logic             skid_zero;
    logic             skid_ones;
    logic             skid_parity;
    logic             take_skid;
    logic             take_in;
    logic             fill_skid;

    logic_unit_core #(.WIDTH(WIDTH)) u_core_skid (
        .op     (skid_op),
        .a      (skid_a),
        .b      (skid_b),
        .res    (skid_res),
        .zero   (skid_zero),
        .ones   (skid_ones),
        .parity (skid_parity)
    );

    assign in_fire   = bus.in_valid && in_ready_q;
    assign take_skid = out_fire && skid_full;
    assign take_in   = in_fire && (!out_valid_q || bus.out_ready);
    assign fill_skid = in_fire && !take_in;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
            zero_q      <= 1'b1;
            ones_q      <= 1'b0;
            parity_q    <= 1'b0;
            skid_full   <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            if (take_skid) begin
                out_q      <= skid_res;
                zero_q     <= skid_zero;
                ones_q     <= skid_ones;
                parity_q   <= skid_parity;
                skid_full  <= 1'b0;
                in_ready_q <= 1'b1;
            end else if (take_in) begin
                out_q       <= in_res;
                zero_q      <= in_zero;
                ones_q      <= in_ones;
                parity_q    <= in_parity;
                out_valid_q <= 1'b1;
            end else if (out_fire) begin
                out_valid_q <= 1'b0;
            end
            if (fill_skid) begin
                skid_full  <= 1'b1;
                in_ready_q <= 1'b0;
            end
        end
    end

    // NOTE: skid payload has no reset; skid_full alone says whether it is meaningful.
    always_ff @(posedge clk) begin
        if (fill_skid) begin
            skid_op <= op_in;
            skid_a  <= bus.a;
            skid_b  <= bus.b;
        end
    end

    assign bus.in_ready = in_ready_q;
`else
    logic in_ready;

    // Combinational from out_ready: a draining result frees the stage this cycle.
    assign in_ready = !out_valid_q || bus.out_ready;
    assign in_fire  = bus.in_valid && in_ready;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
            zero_q      <= 1'b1;
            ones_q      <= 1'b0;
            parity_q    <= 1'b0;
        end else if (in_fire) begin
            out_q       <= in_res;
            zero_q      <= in_zero;
            ones_q      <= in_ones;
            parity_q    <= in_parity;
            out_valid_q <= 1'b1;
        end else if (out_fire) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.in_ready = in_ready;
`endif

    assign bus.out_valid = out_valid_q;
    assign bus.out       = out_q;
    assign bus.zero      = zero_q;
    assign bus.ones      = ones_q;
    assign bus.parity    = parity_q;

endmodule
